// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 key matrix one row at a time, debounces each
// key over consecutive scans and queues press/release events in a FIFO that
// the CPU side pops.
//
// Ports:
//   HCLK          system clock
//   HRESET        synchronous, active-high reset
//   scan_en       enables scanning (examined in IDLE and at row boundaries)
//   col[3:0]      raw column inputs, 1 = key closed on the driven row (async)
//   row[3:0]      one-hot active-high row drive, 0 when not scanning
//   evt_valid     event FIFO non-empty
//   evt_code[4:0] head entry: [4] press(1)/release(0), [3:0] row*4+col
//   evt_pop       pops the head entry; ignored when empty
//   evt_overflow  sticky flag: an event was dropped on a full FIFO
//   clr_ovf       clears evt_overflow
//   irq           level interrupt, equals evt_valid
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYC     = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       scan_en,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       evt_valid,
    output logic [4:0] evt_code,
    input  logic       evt_pop,
    output logic       evt_overflow,
    input  logic       clr_ovf,
    output logic       irq
);

    localparam int unsigned SET_W = 8;
    localparam int unsigned DEB_W = 4;
    localparam int unsigned EVT_W = 5;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_EVAL  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [SET_W-1:0] settle_cnt;
    logic [3:0]       col_s1;
    logic [3:0]       col_s2;
    logic [3:0]       snap;
    logic [15:0]      deb_state;
    logic [DEB_W-1:0] deb_cnt [16];

    logic [EVT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] fifo_cnt_nxt;

    logic [3:0] key_idx;
    logic       key_samp;
    logic       key_diff;
    logic       key_accept;
    logic       fifo_full;
    logic       do_pop;
    logic       do_push;
    logic       evt_drop;

    // Debounce decision for the key under evaluation and FIFO push/pop arbitration.
    always_comb begin
        key_idx      = {row_idx, col_idx};
        key_samp     = snap[col_idx];
        key_diff     = key_samp != deb_state[key_idx];
        key_accept   = (state == ST_EVAL) && key_diff &&
                       (deb_cnt[key_idx] == DEB_W'(DEBOUNCE_SCANS - 1));
        fifo_full    = fifo_cnt == CNT_W'(FIFO_DEPTH);
        do_pop       = evt_pop && (fifo_cnt != '0);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        do_push      = key_accept && (!fifo_full || do_pop);
        evt_drop     = key_accept && fifo_full && !do_pop;
        fifo_cnt_nxt = fifo_cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // First-word fall-through: head shown straight from storage.
    assign evt_code = fifo_mem[rd_ptr];

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            col_s1 <= '0;
            col_s2 <= '0;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    // Scan FSM, row drive and per-key debounce state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            row_idx    <= '0;
            col_idx    <= '0;
            settle_cnt <= '0;
            snap       <= '0;
            row        <= '0;
            deb_state  <= '0;
            for (int i = 0; i < 16; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    row <= '0;
                    if (scan_en) begin
                        state      <= ST_DRIVE;
                        row_idx    <= '0;
                        settle_cnt <= '0;
                        row        <= 4'b0001;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        snap       <= col_s2;
                        col_idx    <= '0;
                        settle_cnt <= '0;
                        state      <= ST_EVAL;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (!key_diff) begin
                        deb_cnt[key_idx] <= '0;
                    end else if (key_accept) begin
                        deb_state[key_idx] <= key_samp;
                        deb_cnt[key_idx]   <= '0;
                    end else begin
                        deb_cnt[key_idx] <= deb_cnt[key_idx] + DEB_W'(1);
                    end

                    if (col_idx == 2'd3) begin
                        if (scan_en) begin
                            row_idx <= row_idx + 2'd1;
                            row     <= 4'(4'b0001 << (row_idx + 2'd1));
                            state   <= ST_DRIVE;
                        end else begin
                            row_idx <= '0;
                            row     <= '0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        col_idx <= col_idx + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    row   <= '0;
                end
            endcase
        end
    end

    // Event FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            evt_valid    <= 1'b0;
            irq          <= 1'b0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= {key_samp, key_idx};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt  <= fifo_cnt_nxt;
            evt_valid <= fifo_cnt_nxt != '0;
            irq       <= fifo_cnt_nxt != '0;
            // A drop in the same cycle as a clear leaves the flag set.
            if (evt_drop) begin
                evt_overflow <= 1'b1;
            end else if (clr_ovf) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: drives the key matrix from a 16-bit key set,
// models debounce and the event FIFO once per full scan, and compares the
// event stream, flags and interrupt against that model.
module tb_keypad_scan_ctrl;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned DEB     = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ROW_PER = SETTLE + 4;

    logic       HCLK;
    logic       HRESET;
    logic       scan_en;
    logic [3:0] col;
    logic [3:0] row;
    logic       evt_valid;
    logic [4:0] evt_code;
    logic       evt_pop;
    logic       evt_overflow;
    logic       clr_ovf;
    logic       irq;

    keypad_scan_ctrl #(
        .SETTLE_CYC     (SETTLE),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .scan_en      (scan_en),
        .col          (col),
        .row          (row),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_pop      (evt_pop),
        .evt_overflow (evt_overflow),
        .clr_ovf      (clr_ovf),
        .irq          (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Key matrix: a closed key connects its row drive to its column line.
    logic [15:0] cur_keys;
    always_comb begin
        col = '0;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | cur_keys[r*4 +: 4];
        end
    end

    int n_vec;
    int n_mis;
    int wait_cycles;

    // Scan-level reference model.
    bit         deb_m [16];
    int         cnt_m [16];
    logic [4:0] mq [$];
    bit         movf;

    // Observations at scan start and popped entries (valid,code).
    logic       obs_valid, obs_irq, obs_ovf;
    logic [4:0] obs_code;
    logic       exp_valid, exp_ovf;
    logic [4:0] exp_code;
    logic [5:0] got_q [$];
    logic [5:0] exp_q [$];

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            deb_m[k] = 1'b0;
            cnt_m[k] = 0;
        end
        mq.delete();
        movf = 1'b0;
    endtask

    // One full scan with a stable key set; keys are visited in index order.
    task automatic model_scan(input logic [15:0] keys);
        for (int k = 0; k < 16; k++) begin
            bit s;
            s = keys[k];
            if (s == deb_m[k]) begin
                cnt_m[k] = 0;
            end else if (cnt_m[k] == int'(DEB) - 1) begin
                deb_m[k] = s;
                cnt_m[k] = 0;
                if (mq.size() < int'(DEPTH)) mq.push_back({s, 4'(k)});
                else movf = 1'b1;
            end else begin
                cnt_m[k] = cnt_m[k] + 1;
            end
        end
    endtask

    // Returns one cycle after row 0 starts being driven (start of a scan).
    task automatic wait_scan_start();
        logic [3:0] prev;
        bit found;
        prev = row;
        found = 1'b0;
        wait_cycles = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge HCLK);
            #1;
            wait_cycles++;
            if (row == 4'b0001 && prev != 4'b0001) found = 1'b1;
            prev = row;
        end
        if (!found) begin
            n_vec++;
            n_mis++;
            $display("FAIL scan_start_timeout: row=%b after 200 cycles, want a row-0 start", row);
        end
    endtask

    // Observe outputs at scan start, apply keys, pop/clear in row-0 settle window.
    task automatic run_scan(input logic [15:0] keys, input int npop, input bit clr);
        logic [4:0] head;
        wait_scan_start();
        obs_valid = evt_valid;
        obs_irq   = irq;
        obs_ovf   = evt_overflow;
        obs_code  = evt_code;
        exp_valid = mq.size() != 0;
        exp_ovf   = movf;
        exp_code  = exp_valid ? mq[0] : 5'h00;
        cur_keys  = keys;
        for (int i = 0; i < npop; i++) begin
            if (mq.size() != 0) begin
                head = mq.pop_front();
                got_q.push_back({evt_valid, evt_code});
                exp_q.push_back({1'b1, head});
            end
            evt_pop = 1'b1;
            @(posedge HCLK);
            #1;
            evt_pop = 1'b0;
        end
        if (clr) begin
            clr_ovf = 1'b1;
            @(posedge HCLK);
            #1;
            clr_ovf = 1'b0;
            movf = 1'b0;
        end
        model_scan(keys);
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        outs = {|row, evt_valid, evt_overflow, irq, |evt_code};
        n_vec++;
        if (outs !== 5'b00000) begin
            n_mis++;
            $display("FAIL reset_outputs: row=%b valid=%b ovf=%b irq=%b code=%h, want all 0",
                     row, evt_valid, evt_overflow, irq, evt_code);
        end
        HRESET = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;
        n_vec++;
        if (row !== 4'b0000) begin
            n_mis++;
            $display("FAIL idle_row: row=%b, want 0000 with scan_en=0", row);
        end
    endtask

    task automatic test_single_press();
        logic [5:0] g, e;
        scan_en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            run_scan(16'h0040, (s == 4) ? 1 : 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL single_press scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
            if (s == 4) begin
                n_vec++;
                if (obs_code !== 5'h16 || obs_irq !== 1'b1) begin
                    n_mis++;
                    $display("FAIL press_k6: code=%h irq=%b, want code=16 irq=1", obs_code, obs_irq);
                end
            end
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL single_press_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_release();
        logic [15:0] seq [13];
        logic [5:0] g, e;
        for (int s = 0; s < 5; s++) seq[s] = 16'h0000;
        for (int s = 5; s < 8; s++) seq[s] = 16'h0001;
        for (int s = 8; s < 13; s++) seq[s] = 16'h0000;
        for (int s = 0; s < 13; s++) begin
            run_scan(seq[s], (s == 4) ? 1 : 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL release scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
            if (s == 4) begin
                n_vec++;
                if (obs_code !== 5'h06) begin
                    n_mis++;
                    $display("FAIL release_k6: code=%h, want 06", obs_code);
                end
            end
            if (s > 5) begin
                n_vec++;
                if (obs_valid !== 1'b0) begin
                    n_mis++;
                    $display("FAIL short_hold scan%0d: valid=%b, want 0", s, obs_valid);
                end
            end
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL release_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] seq [13];
        int          npop [13];
        logic [5:0]  g, e;
        seq[0] = 16'h8421;
        for (int s = 1; s < 7; s++) seq[s] = 16'h8669;
        for (int s = 7; s < 13; s++) seq[s] = 16'h0000;
        for (int s = 0; s < 13; s++) npop[s] = 0;
        npop[6]  = 4;
        npop[11] = 4;
        for (int s = 0; s < 13; s++) begin
            run_scan(seq[s], npop[s], s == 11);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL overflow scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
            if (s == 5 || s == 12) begin
                n_vec++;
                if (obs_ovf !== (s == 5)) begin
                    n_mis++;
                    $display("FAIL ovf_flag scan%0d: ovf=%b, want %b", s, obs_ovf, s == 5);
                end
            end
        end
        n_vec++;
        if (got_q.size() != 8 || got_q[0] !== 6'h30 || got_q[3] !== 6'h3F) begin
            n_mis++;
            $display("FAIL overflow_order: n=%0d first=%h fourth=%h, want n=8 first=30 fourth=3f",
                     got_q.size(), got_q[0], got_q[3]);
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL overflow_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_same_row();
        logic [5:0] g, e;
        for (int s = 0; s < 11; s++) begin
            run_scan((s < 5) ? 16'h0900 : 16'h0000, (s == 4 || s == 10) ? 2 : 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL same_row scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        n_vec++;
        if (got_q.size() != 4 || got_q[0] !== 6'h38 || got_q[1] !== 6'h3B) begin
            n_mis++;
            $display("FAIL same_row_order: n=%0d first=%h second=%h, want n=4 first=38 second=3b",
                     got_q.size(), got_q[0], got_q[1]);
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL same_row_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_pop_on_push();
        logic [4:0] head;
        logic [5:0] g, e;
        cur_keys = 16'h0000;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();
        for (int s = 0; s < 7; s++) begin
            run_scan((s < 4) ? 16'h001E : 16'h021E, 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL pop_on_push scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        // Scan in which key 9 is accepted while the FIFO is full.
        wait_scan_start();
        head = mq.pop_front();
        model_scan(16'h021E);
        // Key 9 (row 2, col 1) pushes on edge 2*ROW_PER + SETTLE + 2 after row 0 starts.
        repeat (ROW_PER*2 + SETTLE + 1) @(posedge HCLK);
        #1;
        n_vec++;
        if (evt_valid !== 1'b1 || evt_code !== head || head !== 5'h11) begin
            n_mis++;
            $display("FAIL full_head: valid=%b code=%h, want valid=1 code=11", evt_valid, evt_code);
        end
        evt_pop = 1'b1;
        @(posedge HCLK);
        #1;
        evt_pop = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b1 || evt_overflow !== 1'b0 || evt_code !== mq[0] || mq.size() != 4) begin
            n_mis++;
            $display("FAIL pop_with_push: valid=%b ovf=%b code=%h, want valid=1 ovf=0 code=%h",
                     evt_valid, evt_overflow, evt_code, mq[0]);
        end
        for (int s = 0; s < 2; s++) begin
            run_scan(16'h021E, (s == 0) ? 4 : 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL pop_on_push_drain scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        n_vec++;
        if (got_q.size() != 4 || got_q[3] !== 6'h39) begin
            n_mis++;
            $display("FAIL pop_on_push_count: n=%0d last=%h, want n=4 last=39", got_q.size(), got_q[3]);
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL pop_on_push_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        logic [4:0] outs;
        logic [5:0] g, e;
        for (int s = 0; s < 2; s++) run_scan(16'h2000, 0, 1'b0);
        wait_scan_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge HCLK);
            #1;
            if (row == 4'b0100) found = 1'b1;
        end
        repeat (3) @(posedge HCLK);
        #1;
        n_vec++;
        if (!found || row !== 4'b0100) begin
            n_mis++;
            $display("FAIL row2_drive: row=%b found=%b, want 0100", row, found);
        end
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        outs = {|row, evt_valid, evt_overflow, irq, |evt_code};
        n_vec++;
        if (outs !== 5'b00000) begin
            n_mis++;
            $display("FAIL midscan_reset: row=%b valid=%b ovf=%b irq=%b code=%h, want all 0",
                     row, evt_valid, evt_overflow, irq, evt_code);
        end
        HRESET = 1'b0;
        model_reset();
        for (int s = 0; s < 5; s++) begin
            run_scan(16'h2000, 0, 1'b0);
            if (s == 0) begin
                n_vec++;
                if (wait_cycles != 1) begin
                    n_mis++;
                    $display("FAIL restart_row0: row 0 after %0d cycles, want 1", wait_cycles);
                end
            end
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL redebounce scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        n_vec++;
        if (obs_code !== 5'h1D) begin
            n_mis++;
            $display("FAIL redebounce_code: code=%h, want 1d", obs_code);
        end
        // Disabling the scan stops row drive but keeps the FIFO and key states.
        scan_en = 1'b0;
        repeat (100) @(posedge HCLK);
        #1;
        n_vec++;
        if (row !== 4'b0000 || evt_valid !== 1'b1 || evt_code !== 5'h1D) begin
            n_mis++;
            $display("FAIL scan_disable: row=%b valid=%b code=%h, want row=0000 valid=1 code=1d",
                     row, evt_valid, evt_code);
        end
        scan_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            run_scan(16'h2000, (s == 0) ? 1 : 0, 1'b0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL rescan scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL rescan_pop: got %h, want %h", g, e);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int          k;
        logic [5:0]  g, e;
        keys = cur_keys;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 15));
                keys[k] = ~keys[k];
            end
            run_scan(keys, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            n_vec++;
            if (obs_valid !== exp_valid || obs_irq !== exp_valid || obs_ovf !== exp_ovf ||
                (exp_valid && obs_code !== exp_code)) begin
                n_mis++;
                $display("FAIL random scan%0d: valid=%b irq=%b ovf=%b code=%h, want valid=%b ovf=%b code=%h",
                         s, obs_valid, obs_irq, obs_ovf, obs_code, exp_valid, exp_ovf, exp_code);
            end
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL random_pop: got %h, want %h", g, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_mis    = 0;
        HRESET   = 1'b1;
        scan_en  = 1'b0;
        evt_pop  = 1'b0;
        clr_ovf  = 1'b0;
        cur_keys = 16'h0000;
        model_reset();
        test_reset();
        test_single_press();
        test_release();
        test_overflow();
        test_same_row();
        test_pop_on_push();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
